// File: rtl/mouse_cursor.sv
// Folds PS/2 mouse packets into an absolute, clamped cursor position and
// derives button state, press/release ticks and a left double-click event.
module mouse_cursor #(
    parameter int unsigned H_MAX      = 639,
    parameter int unsigned V_MAX      = 479,
    parameter int unsigned H_INIT     = 320,
    parameter int unsigned V_INIT     = 240,
    parameter int unsigned DBL_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] x,
    input  logic [8:0] y,
    input  logic [2:0] btn,
    input  logic       m_done_tick,
    input  logic       center,
    output logic [9:0] cursor_x,
    output logic [9:0] cursor_y,
    output logic [2:0] btn_state,
    output logic       left_press_tick,
    output logic       left_release_tick,
    output logic       right_press_tick,
    output logic       dbl_click_tick,
    output logic       update_tick
);
    localparam int unsigned       CW      = (DBL_CYCLES > 0) ? $clog2(DBL_CYCLES + 1) : 1;
    localparam logic [CW-1:0]     CNT_MAX = CW'(DBL_CYCLES);
    localparam logic signed [11:0] H_MAX_S = 12'(H_MAX);
    localparam logic signed [11:0] V_MAX_S = 12'(V_MAX);

    typedef enum logic [1:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2
    } dbl_state_t;

    dbl_state_t        state;
    logic [CW-1:0]     cnt;
    logic signed [11:0] nx;
    logic signed [11:0] ny;
    logic [9:0]        nx_clamped;
    logic [9:0]        ny_clamped;
    logic              left_press;
    logic              left_release;
    logic              right_press;
    logic              timeout;

    // Screen Y grows downward, so upward mouse motion is subtracted.
    always_comb begin
        nx = $signed({2'b00, cursor_x}) + $signed({{3{x[8]}}, x});
        ny = $signed({2'b00, cursor_y}) - $signed({{3{y[8]}}, y});

        if (nx[11])             nx_clamped = '0;
        else if (nx > H_MAX_S)  nx_clamped = 10'(H_MAX);
        else                    nx_clamped = nx[9:0];

        if (ny[11])             ny_clamped = '0;
        else if (ny > V_MAX_S)  ny_clamped = 10'(V_MAX);
        else                    ny_clamped = ny[9:0];
    end

    always_comb begin
        left_press   = m_done_tick &  btn[0] & ~btn_state[0];
        left_release = m_done_tick & ~btn[0] &  btn_state[0];
        right_press  = m_done_tick &  btn[1] & ~btn_state[1];
        timeout      = ((state == PRESS1) || (state == WAIT2)) && (cnt == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cursor_x          <= 10'(H_INIT);
            cursor_y          <= 10'(V_INIT);
            btn_state         <= '0;
            left_press_tick   <= 1'b0;
            left_release_tick <= 1'b0;
            right_press_tick  <= 1'b0;
            update_tick       <= 1'b0;
        end else begin
            left_press_tick   <= left_press;
            left_release_tick <= left_release;
            right_press_tick  <= right_press;
            update_tick       <= m_done_tick | center;
            if (m_done_tick) btn_state <= btn;
            if (center) begin
                cursor_x <= 10'(H_INIT);
                cursor_y <= 10'(V_INIT);
            end else if (m_done_tick) begin
                cursor_x <= nx_clamped;
                cursor_y <= ny_clamped;
            end
        end
    end

    // A timeout takes precedence; a press landing on it restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            dbl_click_tick <= 1'b0;
        end else begin
            dbl_click_tick <= 1'b0;
            if (timeout) begin
                if (left_press) begin
                    state <= PRESS1;
                    cnt   <= '0;
                end else begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (left_press) begin
                            state <= PRESS1;
                            cnt   <= '0;
                        end
                    end
                    PRESS1: begin
                        if (cnt < CNT_MAX) cnt <= cnt + CW'(1);
                        if (left_release) state <= WAIT2;
                    end
                    WAIT2: begin
                        if (cnt < CNT_MAX) cnt <= cnt + CW'(1);
                        if (left_press) begin
                            dbl_click_tick <= 1'b1;
                            state          <= PRESS2;
                        end
                    end
                    PRESS2: begin
                        if (left_release) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
